// File: rtl/ps2_digit_pkg.sv
// Shared constants for the PS/2 digit-entry cursor: scancodes, FSM states,
// default grid geometry and a constant shift-add multiply helper.
package ps2_digit_pkg;

    localparam int DEF_CELL_W = 40;
    localparam int DEF_CELL_H = 40;
    localparam int DEF_COLS   = 16;
    localparam int DEF_ROWS   = 12;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_BKSP  = 8'h66;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BRK,
        ST_EXT,
        ST_EXT_BRK
    } ps2_state_e;

    // Multiply by an elaboration-time constant using only shifted adds.
    function automatic logic [9:0] const_mul(input logic [9:0] a, input int unsigned k);
        logic [9:0] acc;
        acc = '0;
        for (int i = 0; i < 10; i++) begin
            if (k[i]) begin
                acc = acc + (a << i);
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/ps2_digit_lut.sv
// Combinational map from PS/2 set-2 make codes of the top-row digit keys
// to their 4-bit digit value.
module ps2_digit_lut (
    input  logic [7:0] scan,
    output logic       hit,
    output logic [3:0] value
);

    always_comb begin
        hit   = 1'b1;
        value = 4'd0;
        case (scan)
            8'h45:   value = 4'd0;
            8'h16:   value = 4'd1;
            8'h1E:   value = 4'd2;
            8'h26:   value = 4'd3;
            8'h25:   value = 4'd4;
            8'h2E:   value = 4'd5;
            8'h36:   value = 4'd6;
            8'h3D:   value = 4'd7;
            8'h3E:   value = 4'd8;
            8'h46:   value = 4'd9;
            default: hit   = 1'b0;
        endcase
    end

endmodule

// File: rtl/ps2_digit_cursor.sv
// Turns PS/2 scancodes into a current digit and a character-cell cursor,
// presenting the cursor as registered pixel coordinates for the VGA stage.
module ps2_digit_cursor
    import ps2_digit_pkg::*;
#(
    parameter int CELL_W = DEF_CELL_W,
    parameter int CELL_H = DEF_CELL_H,
    parameter int COLS   = DEF_COLS,
    parameter int ROWS   = DEF_ROWS
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic [7:0] iscan,
    input  logic       iscan_valid,
    output logic [7:0] odigit,
    output logic [9:0] ocur_x,
    output logic [9:0] ocur_y,
    output logic       oupdate
);

    localparam logic [9:0] LAST_COL = 10'(COLS - 1);
    localparam logic [9:0] LAST_ROW = 10'(ROWS - 1);

    ps2_state_e state_q, state_d;
    logic [9:0] col_q, col_d;
    logic [9:0] row_q, row_d;
    logic [7:0] digit_q, digit_d;
    logic [9:0] cur_x_q, cur_x_d;
    logic [9:0] cur_y_q, cur_y_d;
    logic       update_q, update_d;

    logic       lut_hit;
    logic [3:0] lut_value;

    logic [9:0] col_inc, col_dec, row_inc, row_dec;

    ps2_digit_lut u_lut (
        .scan  (iscan),
        .hit   (lut_hit),
        .value (lut_value)
    );

    assign col_inc = (col_q == LAST_COL) ? 10'd0 : col_q + 10'd1;
    assign col_dec = (col_q == 10'd0) ? LAST_COL : col_q - 10'd1;
    assign row_inc = (row_q == LAST_ROW) ? 10'd0 : row_q + 10'd1;
    assign row_dec = (row_q == 10'd0) ? LAST_ROW : row_q - 10'd1;

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        digit_d  = digit_q;
        update_d = 1'b0;

        if (iscan_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (iscan == SC_BREAK) begin
                        state_d = ST_BRK;
                    end else if (iscan == SC_EXT) begin
                        state_d = ST_EXT;
                    end else if (lut_hit) begin
                        digit_d  = {4'h0, lut_value};
                        col_d    = col_inc;
                        row_d    = (col_q == LAST_COL) ? row_inc : row_q;
                        update_d = 1'b1;
                    end else if (iscan == SC_ENTER) begin
                        col_d    = 10'd0;
                        row_d    = row_inc;
                        update_d = 1'b1;
                    end else if (iscan == SC_BKSP) begin
                        // Backspace stops dead at the home cell instead of wrapping.
                        if (col_q != 10'd0) begin
                            col_d    = col_dec;
                            update_d = 1'b1;
                        end else if (row_q != 10'd0) begin
                            col_d    = LAST_COL;
                            row_d    = row_dec;
                            update_d = 1'b1;
                        end
                    end
                end
                ST_EXT: begin
                    state_d = ST_IDLE;
                    case (iscan)
                        SC_BREAK: state_d = ST_EXT_BRK;
                        SC_LEFT:  begin col_d = col_dec; update_d = 1'b1; end
                        SC_RIGHT: begin col_d = col_inc; update_d = 1'b1; end
                        SC_UP:    begin row_d = row_dec; update_d = 1'b1; end
                        SC_DOWN:  begin row_d = row_inc; update_d = 1'b1; end
                        default:  ;
                    endcase
                end
                default: state_d = ST_IDLE;
            endcase
        end

        cur_x_d = const_mul(col_d, CELL_W);
        cur_y_d = const_mul(row_d, CELL_H);
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q  <= ST_IDLE;
            col_q    <= '0;
            row_q    <= '0;
            digit_q  <= 8'h00;
            cur_x_q  <= '0;
            cur_y_q  <= '0;
            update_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            digit_q  <= digit_d;
            cur_x_q  <= cur_x_d;
            cur_y_q  <= cur_y_d;
            update_q <= update_d;
        end
    end

    assign odigit  = digit_q;
    assign ocur_x  = cur_x_q;
    assign ocur_y  = cur_y_q;
    assign oupdate = update_q;

endmodule

// File: tb/tb_ps2_digit_cursor.sv
// Scoreboard bench for ps2_digit_cursor: directed scancode sequences push the
// expected post-update outputs; a monitor pops one entry per oupdate pulse.
module tb_ps2_digit_cursor;

    typedef struct packed {
        logic [7:0] digit;
        logic [9:0] x;
        logic [9:0] y;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [7:0] iscan;
    logic       iscan_valid;
    logic [7:0] odigit;
    logic [9:0] ocur_x;
    logic [9:0] ocur_y;
    logic       oupdate;

    exp_t exp_q[$];
    exp_t mon_e;
    int   tests_run    = 0;
    int   tests_failed = 0;

    logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                     8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

    ps2_digit_cursor dut (
        .iCLK        (clk),
        .iRST        (rst),
        .iscan       (iscan),
        .iscan_valid (iscan_valid),
        .odigit      (odigit),
        .ocur_x      (ocur_x),
        .ocur_y      (ocur_y),
        .oupdate     (oupdate)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (oupdate === 1'b1) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("[TB] FAIL unexpected_update: got digit=%h x=%0d y=%0d, no update expected",
                         odigit, ocur_x, ocur_y);
            end else begin
                mon_e = exp_q.pop_front();
                if (odigit !== mon_e.digit || ocur_x !== mon_e.x || ocur_y !== mon_e.y) begin
                    tests_failed++;
                    $display("[TB] FAIL update_value: got digit=%h x=%0d y=%0d, expected digit=%h x=%0d y=%0d",
                             odigit, ocur_x, ocur_y, mon_e.digit, mon_e.x, mon_e.y);
                end
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] code, input bit exp_upd,
                                 input logic [7:0] e_digit, input logic [9:0] e_x,
                                 input logic [9:0] e_y);
        exp_t e;
        @(negedge clk);
        iscan       = code;
        iscan_valid = 1'b1;
        if (exp_upd) begin
            e.digit = e_digit;
            e.x     = e_x;
            e.y     = e_y;
            exp_q.push_back(e);
        end
        @(negedge clk);
        iscan_valid = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] e_digit,
                               input logic [9:0] e_x, input logic [9:0] e_y);
        tests_run++;
        if (odigit !== e_digit || ocur_x !== e_x || ocur_y !== e_y) begin
            tests_failed++;
            $display("[TB] FAIL %s: got digit=%h x=%0d y=%0d, expected digit=%h x=%0d y=%0d",
                     name, odigit, ocur_x, ocur_y, e_digit, e_x, e_y);
        end
    endtask

    task automatic checkDrained(input string name);
        @(negedge clk);
        #1;
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d expected updates still pending, expected 0",
                     name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        rst         = 1'b1;
        iscan       = 8'h16;
        iscan_valid = 1'b1;
        repeat (2) @(negedge clk);
        rst         = 1'b0;
        iscan_valid = 1'b0;
        checkOutput("reset_state", 8'h00, 10'd0, 10'd0);

        applyStimulus(8'h16, 1'b1, 8'h01, 10'd40, 10'd0);
        applyStimulus(8'hF0, 1'b0, 8'h00, 10'd0, 10'd0);
        applyStimulus(8'h16, 1'b0, 8'h00, 10'd0, 10'd0);
        checkOutput("make_break_16", 8'h01, 10'd40, 10'd0);
        checkDrained("make_break_16_drained");

        doReset();
        for (int i = 0; i < 16; i++) begin
            n = i + 1;
            applyStimulus(digit_codes[i % 10], 1'b1, 8'(i % 10),
                          10'((n % 16) * 40), 10'((n / 16) * 40));
        end
        checkOutput("sixteen_digits_wrap", 8'h05, 10'd0, 10'd40);
        checkDrained("sixteen_digits_drained");

        doReset();
        applyStimulus(8'hE0, 1'b0, 8'h00, 10'd0, 10'd0);
        applyStimulus(8'h75, 1'b1, 8'h00, 10'd0, 10'd440);
        checkOutput("ext_up_wrap", 8'h00, 10'd0, 10'd440);
        applyStimulus(8'hE0, 1'b0, 8'h00, 10'd0, 10'd0);
        applyStimulus(8'hF0, 1'b0, 8'h00, 10'd0, 10'd0);
        applyStimulus(8'h75, 1'b0, 8'h00, 10'd0, 10'd0);
        checkOutput("ext_break_ignored", 8'h00, 10'd0, 10'd440);
        checkDrained("ext_drained");

        doReset();
        applyStimulus(8'h66, 1'b0, 8'h00, 10'd0, 10'd0);
        checkOutput("bksp_at_origin", 8'h00, 10'd0, 10'd0);
        applyStimulus(8'h45, 1'b1, 8'h00, 10'd40, 10'd0);
        applyStimulus(8'h66, 1'b1, 8'h00, 10'd0, 10'd0);
        checkOutput("digit_then_bksp", 8'h00, 10'd0, 10'd0);
        checkDrained("bksp_drained");

        doReset();
        applyStimulus(8'hF0, 1'b0, 8'h00, 10'd0, 10'd0);
        doReset();
        applyStimulus(8'h26, 1'b1, 8'h03, 10'd40, 10'd0);
        checkOutput("prefix_discarded", 8'h03, 10'd40, 10'd0);

        applyStimulus(8'h1C, 1'b0, 8'h00, 10'd0, 10'd0);
        @(negedge clk);
        iscan = 8'h16;
        repeat (3) @(negedge clk);
        checkOutput("unmapped_and_invalid", 8'h03, 10'd40, 10'd0);
        checkDrained("unmapped_drained");

        applyStimulus(8'h5A, 1'b1, 8'h03, 10'd0, 10'd40);
        applyStimulus(8'h66, 1'b1, 8'h03, 10'd600, 10'd0);
        checkOutput("enter_then_bksp_wrap", 8'h03, 10'd600, 10'd0);
        applyStimulus(8'hE0, 1'b0, 8'h00, 10'd0, 10'd0);
        applyStimulus(8'h6B, 1'b1, 8'h03, 10'd560, 10'd0);
        applyStimulus(8'hE0, 1'b0, 8'h00, 10'd0, 10'd0);
        applyStimulus(8'h72, 1'b1, 8'h03, 10'd560, 10'd40);
        applyStimulus(8'hE0, 1'b0, 8'h00, 10'd0, 10'd0);
        applyStimulus(8'h74, 1'b1, 8'h03, 10'd600, 10'd40);
        applyStimulus(8'hE0, 1'b0, 8'h00, 10'd0, 10'd0);
        applyStimulus(8'h70, 1'b0, 8'h00, 10'd0, 10'd0);
        checkOutput("arrows_and_unknown_ext", 8'h03, 10'd600, 10'd40);
        applyStimulus(8'h16, 1'b1, 8'h01, 10'd0, 10'd80);
        applyStimulus(8'h16, 1'b1, 8'h01, 10'd40, 10'd80);
        checkOutput("typematic", 8'h01, 10'd40, 10'd80);
        applyStimulus(8'hE0, 1'b0, 8'h00, 10'd0, 10'd0);
        applyStimulus(8'h6B, 1'b1, 8'h01, 10'd0, 10'd80);
        applyStimulus(8'hE0, 1'b0, 8'h00, 10'd0, 10'd0);
        applyStimulus(8'h6B, 1'b1, 8'h01, 10'd600, 10'd80);
        checkOutput("left_wrap", 8'h01, 10'd600, 10'd80);
        checkDrained("arrows_drained");

        doReset();
        checkOutput("final_reset", 8'h00, 10'd0, 10'd0);
        checkDrained("final_drained");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ps2_digit_cursor.md
PS2_DIGIT_CURSOR -- requirements
Module: ps2_digit_cursor

Interface
REQ-001 SHALL have parameter CELL_W, default 40, pixel width of one character cell.
REQ-002 SHALL have parameter CELL_H, default 40, pixel height of one character cell.
REQ-003 SHALL have parameter COLS, default 16, character cells per row.
REQ-004 SHALL have parameter ROWS, default 12, character rows per screen.
REQ-005 SHALL have port iCLK  in  1  sole clock; all logic rises on posedge iCLK.
REQ-006 SHALL have port iRST  in  1  synchronous, active-high reset.
REQ-007 SHALL have port iscan  in  8  scancode byte from the PS/2 receiver.
REQ-008 SHALL have port iscan_valid  in  1  single-cycle strobe qualifying iscan.
REQ-009 SHALL have port odigit  out  8  digit value 8'h00-8'h09, drives the VGA pattern stage ascii input.
REQ-010 SHALL have port ocur_x  out  10  pixel X of the current cell's left edge.
REQ-011 SHALL have port ocur_y  out  10  pixel Y of the current cell's top edge.
REQ-012 SHALL have port oupdate  out  1  one-cycle pulse when odigit or the cursor changes.

Function
REQ-013 SHALL sample iscan only in cycles where iscan_valid=1; other cycles hold all state.
REQ-014 SHALL run FSM states IDLE, BRK, EXT, EXT_BRK.
REQ-015 SHALL transition: IDLE+F0->BRK; IDLE+E0->EXT; EXT+F0->EXT_BRK; BRK, EXT_BRK + any byte->IDLE with no action; EXT + non-F0 byte->IDLE after action.
REQ-016 SHALL map IDLE make codes 45,16,1E,26,25,2E,36,3D,3E,46 to digits 0-9; odigit gets the value and the cursor advances one cell.
REQ-017 SHALL treat IDLE 5A (Enter) as: column=0, row+1.
REQ-018 SHALL treat IDLE 66 (Backspace) as: step back one cell, odigit unchanged; at column 0 go to COLS-1 of the previous row; at row 0 column 0 no move and no oupdate.
REQ-019 SHALL treat EXT codes 6B/74/75/72 as left/right/up/down one cell, odigit unchanged; other EXT codes are ignored.
REQ-020 SHALL advance from column COLS-1 to column 0 of row+1; row ROWS-1 plus one wraps to row 0; left/up at 0 wrap to COLS-1/ROWS-1.
REQ-021 SHALL ignore unrecognised IDLE codes, stay in IDLE, and produce no oupdate.
REQ-022 SHALL treat repeated make codes (typematic) as independent keypresses.
REQ-023 SHALL register ocur_x=col*CELL_W and ocur_y=row*CELL_H so they settle the cycle after the strobe; shifts and adds only, no multiplier.
REQ-024 SHALL assert oupdate one cycle after the accepted strobe, in the same cycle the outputs change.
REQ-025 SHALL keep the result of every CELL_W*(COLS-1) and CELL_H*(ROWS-1) product within 10 bits; products >1023 are illegal parameter sets.

Reset
REQ-026 SHALL, while iRST=1 on a clock edge, force state=IDLE, col=0, row=0, odigit=8'h00, ocur_x=0, ocur_y=0, oupdate=0.
REQ-027 SHALL give iRST priority over a coincident iscan_valid; that byte is dropped.
REQ-028 SHALL discard any pending F0/E0 prefix on reset mid-sequence.

Structure
REQ-029 SHALL place scancode constants (F0, E0, 5A, 66, arrow codes), the FSM state enum, and the default cell and grid parameters in package ps2_digit_pkg.
REQ-030 SHALL implement the combinational scancode-to-digit map as sub-module ps2_digit_lut (out: hit, 4-bit value).

Verification
REQ-031 SHALL cover: reset, then bytes 16, F0, 16 -> odigit=01, ocur_x=40, ocur_y=0, exactly one oupdate.
REQ-032 SHALL cover: 16 digit presses from reset -> after the 16th, ocur_x=0, ocur_y=40.
REQ-033 SHALL cover: E0 75 from reset -> ocur_y=440 (row 11), ocur_x=0; then E0 F0 75 -> no change.
REQ-034 SHALL cover: 66 from reset -> no oupdate and cursor stays 0,0; then 45, 66 -> odigit=00, cursor back at 0,0.
REQ-035 SHALL cover: byte F0 then iRST pulse then 26 -> odigit=03 (the prefix was discarded).
REQ-036 SHALL cover: iscan=1C (unmapped) and iscan_valid=0 with iscan=16 -> no output change, no oupdate.
